// File: rtl/skintone_result_packer_pkg.sv
// -----------------------------------------------------------------------------
// skintone_result_packer_pkg
// Shared widths, the FIFO entry layout and the byte-keep helper used by the
// skin-score packer and its word FIFO.
// -----------------------------------------------------------------------------
package skintone_result_packer_pkg;

  localparam int SCORE_WIDTH    = 8;
  localparam int PACKED_WIDTH   = 32;
  localparam int LANES_PER_WORD = 4;
  localparam int KEEP_WIDTH     = LANES_PER_WORD;
  localparam int ENTRY_WIDTH    = PACKED_WIDTH + KEEP_WIDTH;

  typedef logic [1:0] lane_cnt_t;

  // One FIFO entry: keep mask in the top bits, packed word below.
  typedef struct packed {
    logic [KEEP_WIDTH-1:0]   keep;
    logic [PACKED_WIDTH-1:0] data;
  } word_entry_t;

  // Keep mask for a word holding n_bytes valid lanes starting at lane 0.
  function automatic logic [KEEP_WIDTH-1:0] keep_mask(input logic [2:0] n_bytes);
    logic [KEEP_WIDTH-1:0] mask;
    case (n_bytes)
      3'd0:    mask = 4'h0;
      3'd1:    mask = 4'h1;
      3'd2:    mask = 4'h3;
      3'd3:    mask = 4'h7;
      3'd4:    mask = 4'hF;
      default: mask = 4'h0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/skintone_result_packer_if.sv
// -----------------------------------------------------------------------------
// skintone_result_packer_if
// Packed-word stream towards the memory write master.
//   word_dataout        packed word, lane 0 in bits [7:0] (earliest score)
//   word_keep           byte-lane valid mask
//   word_dataout_valid  head entry valid
//   word_dataout_ready  consumer accepts when valid && ready
// master = packer side, slave = consumer side.
// -----------------------------------------------------------------------------
interface skintone_result_packer_if;
  import skintone_result_packer_pkg::*;

  logic [PACKED_WIDTH-1:0] word_dataout;
  logic [KEEP_WIDTH-1:0]   word_keep;
  logic                    word_dataout_valid;
  logic                    word_dataout_ready;

  modport master (
    output word_dataout,
    output word_keep,
    output word_dataout_valid,
    input  word_dataout_ready
  );

  modport slave (
    input  word_dataout,
    input  word_keep,
    input  word_dataout_valid,
    output word_dataout_ready
  );
endinterface

// File: rtl/skintone_sync_fifo.sv
// -----------------------------------------------------------------------------
// skintone_sync_fifo
// Single-clock show-ahead FIFO with registered level / almost-full.
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   push_i          write request; push_data_i written if accepted
//   pop_i           read request; ignored while empty
//   head_o          current head entry (zero while empty)
//   full_o/empty_o  occupancy flags (derived from the registered level)
//   level_o         entries stored
//   almost_full_o   level_o >= AF_LEVEL
//   push_accept_o   the push this cycle is being stored
// A push while full is still accepted when a pop happens on the same edge.
// -----------------------------------------------------------------------------
module skintone_sync_fifo #(
  parameter  int WIDTH    = 36,
  parameter  int DEPTH    = 16,
  parameter  int AF_LEVEL = 12,
  localparam int AW       = $clog2(DEPTH),
  localparam int LW       = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o,
  output logic             almost_full_o,
  output logic             push_accept_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_d;
  logic             almost_full_q;
  logic             pop_s;
  logic             push_s;

  assign full_o        = (level_q == LW'(DEPTH));
  assign empty_o       = (level_q == {LW{1'b0}});
  assign pop_s         = pop_i && !empty_o;
  assign push_s        = push_i && (!full_o || pop_s);
  assign push_accept_o = push_s;
  assign level_o       = level_q;
  assign almost_full_o = almost_full_q;

  // Next occupancy after this edge's push and pop.
  always_comb begin
    level_d = level_q + LW'(push_s) - LW'(pop_s);
  end

  // Head entry; forced to zero when nothing is stored.
  always_comb begin
    if (empty_o) begin
      head_o = {WIDTH{1'b0}};
    end else begin
      head_o = mem_q[rd_ptr_q];
    end
  end

  // Storage, pointers (wrap modulo DEPTH) and registered occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q      <= {AW{1'b0}};
      rd_ptr_q      <= {AW{1'b0}};
      level_q       <= {LW{1'b0}};
      almost_full_q <= 1'b0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      level_q       <= level_d;
      almost_full_q <= (level_d >= LW'(AF_LEVEL));
    end
  end

endmodule

// File: rtl/skintone_result_packer.sv
// -----------------------------------------------------------------------------
// skintone_result_packer
// Packs four consecutive 8-bit skin scores into a 32-bit word (lane 0 =
// earliest score), buffers words in a FIFO and offers them on word_if.
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   score_datain(_valid) score stream from the datapath (cannot be stalled)
//   flush               pulse: emit any partial word
//   word_if             packed-word stream (master side)
//   fifo_level          words stored
//   almost_full         fifo_level >= ALMOST_FULL_LEVEL
//   overflow            sticky: a completed word was dropped on a full FIFO
// -----------------------------------------------------------------------------
module skintone_result_packer
  import skintone_result_packer_pkg::*;
#(
  parameter  int FIFO_DEPTH        = 16,
  parameter  int ALMOST_FULL_LEVEL = 12,
  localparam int LW                = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SCORE_WIDTH-1:0]        score_datain,
  input  logic                          score_datain_valid,
  input  logic                          flush,
  skintone_result_packer_if.master      word_if,
  output logic [LW-1:0]                 fifo_level,
  output logic                          almost_full,
  output logic                          overflow
);

  lane_cnt_t    lane_cnt_q;
  lane_cnt_t    lane_cnt_d;
  logic [23:0]  asm_q;           // lanes 0..2; lane 3 is never registered
  logic [23:0]  asm_d;
  logic [31:0]  merged_s;        // assembly register with the live score inserted
  logic         push_s;
  word_entry_t  push_entry_s;
  word_entry_t  head_s;
  logic         push_accept_s;
  logic         fifo_empty_s;
  logic         pop_s;
  logic         overflow_q;
  logic         overflow_d;

  // Insert the incoming score into its lane of the current assembly.
  always_comb begin
    merged_s = {8'h00, asm_q};
    case (lane_cnt_q)
      2'd0:    merged_s[7:0]   = score_datain;
      2'd1:    merged_s[15:8]  = score_datain;
      2'd2:    merged_s[23:16] = score_datain;
      2'd3:    merged_s[31:24] = score_datain;
      default: merged_s        = {8'h00, asm_q};
    endcase
  end

  // Lane counter, assembly register and push generation (full word or flush).
  always_comb begin
    lane_cnt_d   = lane_cnt_q;
    asm_d        = asm_q;
    push_s       = 1'b0;
    push_entry_s = '0;
    if (score_datain_valid) begin
      if ((lane_cnt_q == 2'd3) || flush) begin
        // Word completes, or flush takes the new score along with it.
        push_s            = 1'b1;
        push_entry_s.data = merged_s;
        push_entry_s.keep = keep_mask({1'b0, lane_cnt_q} + 3'd1);
        lane_cnt_d        = 2'd0;
        asm_d             = 24'h000000;
      end else begin
        asm_d      = merged_s[23:0];
        lane_cnt_d = lane_cnt_q + 2'd1;
      end
    end else if (flush && (lane_cnt_q != 2'd0)) begin
      push_s            = 1'b1;
      push_entry_s.data = {8'h00, asm_q};
      push_entry_s.keep = keep_mask({1'b0, lane_cnt_q});
      lane_cnt_d        = 2'd0;
      asm_d             = 24'h000000;
    end else begin
      lane_cnt_d = lane_cnt_q;
      asm_d      = asm_q;
    end
  end

  // Dropped push (full with no simultaneous pop) latches overflow until reset.
  always_comb begin
    overflow_d = overflow_q | (push_s && !push_accept_s);
  end

  // Packer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_cnt_q <= 2'd0;
      asm_q      <= 24'h000000;
      overflow_q <= 1'b0;
    end else begin
      lane_cnt_q <= lane_cnt_d;
      asm_q      <= asm_d;
      overflow_q <= overflow_d;
    end
  end

  assign pop_s = word_if.word_dataout_valid && word_if.word_dataout_ready;

  skintone_sync_fifo #(
    .WIDTH    (ENTRY_WIDTH),
    .DEPTH    (FIFO_DEPTH),
    .AF_LEVEL (ALMOST_FULL_LEVEL)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .push_i        (push_s),
    .push_data_i   (push_entry_s),
    .pop_i         (pop_s),
    .head_o        (head_s),
    .full_o        (),
    .empty_o       (fifo_empty_s),
    .level_o       (fifo_level),
    .almost_full_o (almost_full),
    .push_accept_o (push_accept_s)
  );

  assign word_if.word_dataout       = head_s.data;
  assign word_if.word_keep          = head_s.keep;
  assign word_if.word_dataout_valid = !fifo_empty_s;
  assign overflow                   = overflow_q;

endmodule

// File: doc/skintone_result_packer.md
Name: skintone_result_packer

Overview:
Sits directly downstream of the skintone datapath and consumes its 8-bit skin-score stream (result_dataout / result_dataout_valid).
- Packs four consecutive scores into one 32-bit word.
- Buffers packed words in a FIFO and presents them to the memory write master over a valid/ready handshake.
- The datapath pipeline cannot stall, so this block absorbs output backpressure and reports occupancy and overflow.

Parameters:
FIFO_DEPTH, 16, number of 32-bit words buffered; power of two, minimum 4.
ALMOST_FULL_LEVEL, 12, fifo_level at or above which almost_full asserts; must be less than FIFO_DEPTH.

Ports:
clk  input  1  single clock; all logic rising-edge.
rst  input  1  asynchronous, active-high reset.
score_datain  input  8  skin score from datapath stage 15.
score_datain_valid  input  1  score_datain is valid this cycle; no ready returned.
flush  input  1  single-cycle pulse (end of frame/line): emit any partial word.
word_dataout  output  32  packed word; lane 0 is bits [7:0] and holds the earliest score.
word_keep  output  4  byte-lane valid mask for word_dataout.
word_dataout_valid  output  1  FIFO head valid.
word_dataout_ready  input  1  consumer accepts the word when valid && ready.
fifo_level  output  $clog2(FIFO_DEPTH)+1  words currently stored.
almost_full  output  1  fifo_level >= ALMOST_FULL_LEVEL; used by the pixel feeder to throttle.
overflow  output  1  sticky; a word was dropped.

Behaviour:
Reset (asynchronous, active-high):
- Lane counter = 0; assembly register = 0; FIFO empty.
- word_dataout_valid = 0, word_dataout = 0, word_keep = 0, fifo_level = 0, almost_full = 0, overflow = 0.
- Reset mid-operation discards partial words and all buffered words.

Packing:
- lane_cnt (2 bits) counts bytes held in the assembly register.
- Each cycle with score_datain_valid, the byte goes to lane lane_cnt and lane_cnt increments, wrapping 3 to 0.
- When the 4th byte arrives, the push word is assembled from lanes 0–2 (register) plus lane 3 (live input), with keep = 4'hF. It is written to the FIFO on that same edge.
- Latency: word_dataout_valid rises on the edge after the 4th score's cycle, if the FIFO was empty.

Flush:
- Flush with lane_cnt = n > 0 and no valid score pushes the partial word: lanes n..3 are zero, keep = (1<<n)-1, lane_cnt becomes 0.
- Flush with a valid score in the same cycle includes that score first.
  - If it completes 4 bytes: exactly one word, keep 4'hF.
  - Otherwise: one partial word with keep = (1<<(n+1))-1.
- Flush with lane_cnt = 0 and no score: no-op, nothing pushed.

FIFO:
- Show-ahead; word_dataout/word_keep are the head entry.
- While valid && !ready, data and keep are held stable.
- Pop when word_dataout_valid && word_dataout_ready.
- Push is accepted if not full, or if full with a pop in the same cycle (level unchanged).
- Push when full with no pop: the new word is dropped, FIFO contents unchanged, overflow set and held until reset. lane_cnt still resets to 0.
- Pointers wrap modulo FIFO_DEPTH.
- fifo_level and almost_full are registered and track the post-edge occupancy.

Arithmetic:
- No arithmetic on scores; pass-through byte packing only.
- Unused lanes are driven to 0.

Decomposition:
- datapath.vh additions: `score_width (8), `packed_width (32), `lanes_per_word (4).
- Sub-module skintone_sync_fifo:
  - Parameterised width (36 = data + keep) and depth.
  - Show-ahead, with full/empty/level outputs and the push-when-full-with-pop rule.
  - Reused later for the pixel input buffer.
- The packer top level holds the lane counter, assembly register, flush logic and overflow flag.

Test Plan:
- Scores 0x11,0x22,0x33,0x44 on consecutive cycles, ready=1 -> one cycle later word_dataout=0x44332211, keep=0xF, valid for exactly one cycle, overflow=0.
- Scores 0xAA,0xBB then flush pulse -> word 0x0000BBAA, keep=0x3; next 4 scores start at lane 0.
- Flush asserted in the same cycle as the 4th score (0x01..0x04) -> exactly one word 0x04030201, keep=0xF; no empty word follows.
- ready=0, stream 68 scores -> fifo_level reaches 16, almost_full at level 12, 17th word dropped, overflow=1. Draining yields the first 16 words in order, unchanged.
- FIFO full, ready=1 on the same cycle a new word completes -> level stays 16, overflow stays 0, new word appears last in order.
- Assert rst mid-stream after 2 scores and 3 buffered words -> all outputs 0 immediately (asynchronous). After release, the next 4 scores form a clean word from lane 0.
